// File: rtl/uart_rx_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_param
// Brief    : Parametrised UART receiver (5-9 data bits, optional parity,
//            1/2 stop bits) feeding a first-word-fall-through receive FIFO
//            with level and idle-timeout interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_param #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int IRQ_THRES    = 4,
    parameter int TIMEOUT_BITS = 5,
    parameter int LW           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          clk_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic [LW-1:0]        level,
    output logic                 irq,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;
    localparam logic [2:0] c_PUSH   = 3'd5;

    localparam logic [LW-1:0] c_DEPTH    = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] c_THRES    = LW'(IRQ_THRES);
    localparam logic [3:0]    c_LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [31:0]   c_TO_LAST  = 32'(TIMEOUT_BITS - 1);

    // Receiver state
    logic                 r_rx_meta;
    logic                 r_rxs;
    logic [2:0]           r_state;
    logic [31:0]          r_div;
    logic [31:0]          r_cnt;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic                 r_stop_idx;

    // FIFO state
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;

    // Timeout / interrupt / flags
    logic [31:0]          r_to_clk;
    logic [31:0]          r_to_bits;
    logic                 r_to_flag;
    logic                 r_irq;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic [31:0]          w_div_eff;
    logic [31:0]          w_half_last;
    logic [31:0]          w_bit_last;
    logic                 w_tick;
    logic                 w_par_en;
    logic                 w_par_exp;
    logic                 w_pop;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_frame_set;
    logic                 w_to_hold;
    logic                 w_to_wrap;

    // Divisors below 4 are clamped so the half-bit count stays meaningful
    assign w_div_eff   = (clk_div < 32'd4) ? 32'd4 : clk_div;
    assign w_half_last = (r_div >> 1) - 32'd1;
    assign w_bit_last  = r_div - 32'd1;
    assign w_tick      = (r_cnt == w_bit_last);

    assign w_par_en    = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    // Odd parity inverts the expected bit
    assign w_par_exp   = (^r_shift) ^ cfg_parity[1];

    assign w_pop       = rd_en && (r_level != '0);
    assign w_push_req  = (r_state == c_PUSH);
    // A full FIFO still accepts when a pop frees a slot on the same edge
    assign w_push      = w_push_req && ((r_level != c_DEPTH) || w_pop);
    assign w_frame_set = (r_state == c_STOP) && w_tick && !r_rxs;

    // Timeout counter only runs while idle with data waiting
    assign w_to_hold   = w_push || w_pop || (r_state != c_IDLE) || !r_rxs || (r_level == '0);
    assign w_to_wrap   = (r_to_clk == (w_div_eff - 32'd1));

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // Frame receive state machine
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_div      <= '0;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_idx <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!r_rxs) begin
                        r_state    <= c_START;
                        r_div      <= w_div_eff;
                        r_cnt      <= '0;
                        r_bit_idx  <= '0;
                        r_par_bad  <= 1'b0;
                        r_stop_idx <= 1'b0;
                    end
                end
                c_START: begin
                    if (r_cnt == w_half_last) begin
                        r_cnt   <= '0;
                        // Line back high at mid-bit means a glitch, not a start bit
                        r_state <= r_rxs ? c_IDLE : c_DATA;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        // Shift in from the top so the first bit lands at bit 0
                        r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_state <= w_par_en ? c_PARITY : c_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_PARITY: begin
                    if (w_tick) begin
                        r_cnt     <= '0;
                        r_par_bad <= (r_rxs != w_par_exp);
                        r_state   <= c_STOP;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (!r_rxs) begin
                            r_state <= c_IDLE;
                        end else if (cfg_stop2 && !r_stop_idx) begin
                            r_stop_idx <= 1'b1;
                        end else begin
                            r_state <= c_PUSH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_PUSH: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents are masked at the output while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Idle-timeout bit-period counter and flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_clk  <= '0;
            r_to_bits <= '0;
            r_to_flag <= 1'b0;
        end else begin
            if (w_to_hold) begin
                r_to_clk  <= '0;
                r_to_bits <= '0;
            end else if (r_to_bits != 32'(TIMEOUT_BITS)) begin
                if (w_to_wrap) begin
                    r_to_clk  <= '0;
                    r_to_bits <= r_to_bits + 32'd1;
                end else begin
                    r_to_clk <= r_to_clk + 32'd1;
                end
            end
            if (w_push || w_pop) begin
                r_to_flag <= 1'b0;
            end else if (!w_to_hold && w_to_wrap && (r_to_bits == c_TO_LAST)) begin
                r_to_flag <= 1'b1;
            end
        end
    end

    // Registered level-type interrupt
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_level >= c_THRES) || (r_to_flag && (r_level != '0));
        end
    end

    // Sticky error flags; a set event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_push && r_par_bad) begin
                r_parity_err <= 1'b1;
            end else if (err_clr) begin
                r_parity_err <= 1'b0;
            end
            if (w_push_req && !w_push) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rd_valid   = (r_level != '0);
    assign rd_data    = rd_valid ? r_mem[r_rd_ptr] : '0;
    assign level      = r_level;
    assign irq        = r_irq;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo_param
// Brief    : Directed self-checking bench for uart_rx_fifo_param
//            (8 data bits, 8-entry FIFO, threshold 4, timeout 5 bits, div 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo_param;

    localparam int c_DIV = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] clk_div;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        rx;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [3:0]  level;
    logic        irq;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;
    logic        err_clr;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_fifo_param #(
        .DATA_BITS    (8),
        .FIFO_DEPTH   (8),
        .IRQ_THRES    (4),
        .TIMEOUT_BITS (5)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_div    (clk_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .rx         (rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .level      (level),
        .irq        (irq),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .err_clr    (err_clr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (c_DIV) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit, stop bit(s)
    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                              input logic two_stop, input logic stop2_val);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_en) send_bit(par_bit);
        send_bit(1'b1);
        if (two_stop) send_bit(stop2_val);
        rx = 1'b1;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    logic [7:0] b;

    initial begin
        rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        clk_div = 32'd16; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_level", 32'(level), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_flags", {29'd0, frame_err, parity_err, overrun}, 0);
        rst_n = 1'b1;
        idle(2);

        // 8N1, 0xA5
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("a5_rd_valid", 32'(rd_valid), 1);
        check("a5_rd_data", 32'(rd_data), 32'hA5);
        check("a5_level", 32'(level), 1);
        check("a5_flags", {29'd0, frame_err, parity_err, overrun}, 0);
        check("a5_busy", 32'(busy), 0);
        pop();
        check("a5_pop_valid", 32'(rd_valid), 0);
        check("a5_pop_level", 32'(level), 0);

        // Even parity, 0x03 has even ones so correct bit is 0; send 1
        cfg_parity = 2'b01;
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("par_err_set", 32'(parity_err), 1);
        check("par_data", 32'(rd_data), 32'h03);
        check("par_level", 32'(level), 1);
        pulse_clr();
        check("par_err_clr", 32'(parity_err), 0);
        pop();

        // Odd parity, 0x03 with correct bit 1
        cfg_parity = 2'b10;
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("odd_no_err", 32'(parity_err), 0);
        check("odd_level", 32'(level), 1);
        pop();
        cfg_parity = 2'b00;

        // Two stop bits, second one low
        cfg_stop2 = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(40);
        check("stop2_frame_err", 32'(frame_err), 1);
        check("stop2_level", 32'(level), 0);
        check("stop2_busy", 32'(busy), 0);
        pulse_clr();
        check("stop2_clr", 32'(frame_err), 0);
        cfg_stop2 = 1'b0;

        // Nine bytes with no reads: level IRQ and overrun
        for (int i = 1; i <= 9; i++) begin
            b = 8'(8'h10 + i);
            send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("fill_irq_%0d", i), 32'(irq), (i >= 4) ? 32'd1 : 32'd0);
        end
        check("full_level", 32'(level), 8);
        check("full_overrun", 32'(overrun), 1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_data_%0d", i), 32'(rd_data), 32'(8'h10 + i));
            pop();
            idle(1);
            check($sformatf("drain_irq_%0d", i), 32'(irq), ((8 - i) >= 4) ? 32'd1 : 32'd0);
        end
        check("drain_empty", 32'(rd_valid), 0);
        pulse_clr();
        check("overrun_clr", 32'(overrun), 0);

        // Idle timeout with a single byte
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        check("to_irq_early", 32'(irq), 0);
        idle(40);
        check("to_irq_mid", 32'(irq), 0);
        idle(45);
        check("to_irq_set", 32'(irq), 1);
        check("to_level", 32'(level), 1);
        pop();
        check("to_pop_level", 32'(level), 0);
        check("to_pop_irq_lag", 32'(irq), 1);
        idle(1);
        check("to_pop_irq_clr", 32'(irq), 0);

        // Three-clock glitch: START entered, no DATA
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        check("glitch_start", 32'(busy), 1);
        idle(15);
        check("glitch_busy", 32'(busy), 0);
        check("glitch_level", 32'(level), 0);
        check("glitch_flags", {29'd0, frame_err, parity_err, overrun}, 0);

        // One byte with bad even parity (0x77 has even ones), then reset mid-DATA
        cfg_parity = 2'b01;
        send_frame(8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("pre_rst_level", 32'(level), 1);
        check("pre_rst_par", 32'(parity_err), 1);
        cfg_parity = 2'b00;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("mid_data_busy", 32'(busy), 1);
        rst_n = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_level", 32'(level), 0);
        check("mrst_rd_valid", 32'(rd_valid), 0);
        check("mrst_rd_data", 32'(rd_data), 0);
        check("mrst_irq", 32'(irq), 0);
        check("mrst_flags", {29'd0, frame_err, parity_err, overrun}, 0);
        rst_n = 1'b1;
        idle(2);

        // Recovery after reset
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("post_rst_data", 32'(rd_data), 32'h96);
        check("post_rst_level", 32'(level), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo_param.md
# uart_rx_fifo_param

Parametrised UART receiver, the successor to the fixed 8N1 receiver. It adds configurable data width, a parity mode, one or two stop bits, and an internal receive FIFO with a programmable IRQ threshold and an idle-timeout interrupt. It sits between the external `rx` pin and the user-project register/Wishbone front end, which drains it through a first-word-fall-through read port.

## Interface
- `DATA_BITS`, 8: data bits per frame (5–9), LSB first.
- `FIFO_DEPTH`, 8: receive FIFO entries (power of 2, ≥2).
- `IRQ_THRES`, 4: FIFO level at which `irq` asserts (1..FIFO_DEPTH).
- `TIMEOUT_BITS`, 5: idle bit-periods with a non-empty FIFO before a timeout IRQ.
- `LW`, $clog2(FIFO_DEPTH+1): width of the level counter.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `clk_div` in 32: clocks per bit. Values below 4 are treated as 4.
- `cfg_parity` in 2: 00 none, 01 even, 10 odd, 11 none.
- `cfg_stop2` in 1: 1 selects two stop bits.
- `rx` in 1: serial input, asynchronous.
- `rd_en` in 1: pop the head entry. Ignored when `rd_valid`=0.
- `rd_data` out DATA_BITS: FIFO head, valid while `rd_valid`=1.
- `rd_valid` out 1: FIFO non-empty.
- `level` out LW: current FIFO occupancy.
- `irq` out 1: level IRQ or timeout IRQ.
- `frame_err` out 1: sticky flag.
- `parity_err` out 1: sticky flag.
- `overrun` out 1: sticky flag.
- `err_clr` in 1: one-cycle pulse that clears all three sticky flags.
- `busy` out 1: a frame is in progress.

## Operation
- `rx` passes through a 2-flop synchroniser. The synchroniser resets to 1; all logic uses the synchronised value `rxs`.
- The effective divisor `div` = max(clk_div, 4). `clk_div` is sampled into a register when leaving IDLE and held constant for the whole frame.

State machine:
- **IDLE**: `rxs`=0 → go to START, clear the bit counter.
- **START**: count to (div>>1)-1, then sample `rxs`.
  - Sample 0 → go to DATA.
  - Sample 1 → false start, return to IDLE. Nothing is pushed and no flag is set.
- **DATA**: sample every div cycles into the shift buffer at `bit_idx` (LSB first).
  - After sample DATA_BITS-1 → go to PARITY if parity is enabled, else go to STOP.
- **PARITY**: sample after div cycles.
  - Mismatch against XOR(data) (even) or ~XOR(data) (odd) → set the per-frame parity flag.
- **STOP**: sample after div cycles.
  - With `cfg_stop2`, a second sample follows div cycles later.
  - Any stop sample = 0 → set `frame_err` and return to IDLE. The frame is discarded.
  - All stop samples = 1 → go to PUSH.
- **PUSH** (one cycle):
  - If the FIFO can accept, write the data. If the per-frame parity flag is set, still write the data and set `parity_err`.
  - If the FIFO cannot accept, drop the data and set `overrun`.
  - Then return to IDLE.
- `busy` = 1 in every state except IDLE.

FIFO:
- Push is accepted when level < FIFO_DEPTH, or when level = FIFO_DEPTH and a pop occurs in the same cycle.
- Simultaneous push and pop leaves `level` unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Timeout:
- A bit-period counter runs only in IDLE with level ≠ 0.
- The counter is cleared on any push, any pop, or when leaving IDLE.
- When the counter reaches TIMEOUT_BITS (TIMEOUT_BITS·div clocks), `to_flag` is set. `to_flag` holds until the next push or pop.

IRQ:
- `irq` is registered: `irq` = (level ≥ IRQ_THRES) | (to_flag & level≠0).
- `irq` is level-type. It is cleared only by draining the FIFO.

Sticky flags:
- `err_clr` clears `frame_err`, `parity_err` and `overrun`.
- If a set event and `err_clr` occur in the same cycle, set wins.

## Timing
Reset values, applied at the first rising edge with `rst_n`=0:
- state IDLE, all counters 0, FIFO pointers 0.
- `level`=0, `rd_valid`=0, `rd_data`=0, `irq`=0, `busy`=0, all flags 0.
- Reset mid-frame aborts the frame with no push.

Latency:
- Falling edge on `rx` to START entry: 3 clocks (2 synchroniser clocks + 1).
- Last stop sample to PUSH: 1 clock.
- PUSH to `rd_valid`=1 and `level` updated: next clock.
- PUSH to `irq` asserted: one further clock, since `irq` is registered.

Read port and flags:
- Pop at edge N: `rd_data` shows the next entry and `level` decrements after edge N.
- Pop while empty has no effect.
- Sticky flags assert on the edge that ends the detecting state.

## Test plan
- **8N1, div=16**: send 0xA5 → after the stop bit, `rd_valid`=1, `rd_data`=0xA5, `level`=1, and no flags set.
- **Parity**: even parity, send 0x03 with the parity bit forced to 1 → `parity_err`=1, 0x03 is still stored. Pulse `err_clr` → `parity_err`=0.
- **Two stop bits, framing**: `cfg_stop2`=1, second stop bit driven 0 → `frame_err`=1 and `level` unchanged.
- **Overrun and level IRQ**: FIFO_DEPTH=8, IRQ_THRES=4, send 9 bytes with no reads.
  - `irq` rises after the 4th byte.
  - After the 9th byte, `level`=8 and `overrun`=1.
  - Popping returns bytes 1..8 in order.
  - `irq` drops once `level`=3.
- **Timeout**: send 1 byte and wait TIMEOUT_BITS·16 clocks → `irq`=1. Pop → `irq`=0 the clock after `level` reaches 0.
- **Glitch and reset**: a 3-clock low pulse on `rx` gives no START→DATA transition and `busy` returns to 0. Asserting `rst_n`=0 mid-DATA gives IDLE, with all outputs at reset values on the next edge.
